// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
//   Multi-digit packed-BCD adder that walks the operands one digit per clock,
//   least-significant digit first, through a single decimal-corrected digit
//   adder. Valid/ready handshake on both the operand and result sides.
//
//   Optional feature macro: BCD_SUB_EN
//     defined   -> sub_i port present; sub_i=1 computes a - b - carry_in
//                  (carry_out_o = 1 means borrow, sum is the ten's complement)
//     undefined -> add only, no sub_i port
//
//   Invalid digits (>9) are flagged on digit_err_o but are otherwise pushed
//   through the same digit rule, so their results are well defined.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    input  logic                  carry_in_i,
`ifdef BCD_SUB_EN
    input  logic                  sub_i,
`endif
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*DIGITS-1:0]   sum_o,
    output logic                  carry_out_o,
    output logic                  digit_err_o
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            c_q, c_d;
    logic            sub_q, sub_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    // Subtract request seen at the operand port; tied low in the add-only build
    // so the datapath below is identical in both configurations.
    logic            sub_in;
`ifdef BCD_SUB_EN
    assign sub_in = sub_i;
`else
    assign sub_in = 1'b0;
`endif

    // Digit-slice signals for the current least-significant working digit.
    logic [3:0]      b_digit;
    logic [4:0]      t_sum;
    logic [3:0]      res_digit;
    logic            c_next;
    logic [W-1:0]    acc_next;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign in_ready_o  = (state_q == S_IDLE) && !reset_i;
    assign out_valid_o = (state_q == S_DONE);
    assign sum_o       = sum_q;
    assign carry_out_o = cout_q;
    assign digit_err_o = err_q;

    // Single decimal-corrected digit adder; subtraction uses the nine's
    // complement of b so the same correction rule applies unchanged.
    always_comb begin
        b_digit   = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
        t_sum     = {1'b0, a_q[3:0]} + {1'b0, b_digit} + {4'b0000, c_q};
        res_digit = t_sum[3:0];
        c_next    = 1'b0;
        if (t_sum > 5'd9) begin
            res_digit = t_sum[3:0] + 4'd6;
            c_next    = 1'b1;
        end
        acc_next               = acc_q >> 4;
        acc_next[W-1 -: 4]     = res_digit;
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_in;
                    c_d     = sub_in ? ~carry_in_i : carry_in_i;
                    err_d   = has_bad_digit(a_i) || has_bad_digit(b_i);
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                acc_d = acc_next;
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DIGIT) begin
                    cnt_d   = '0;
                    sum_d   = acc_next;
                    cout_d  = sub_q ? ~c_next : c_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Testbench for bcd_serial_adder (DIGITS=4). Results are compared against a
// decimal-arithmetic reference model; operands with invalid digits fall back
// to the per-digit rule since they have no decimal value.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10000;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          carry_in_i;
    logic          sub_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  sum_o;
    logic          carry_out_o;
    logic          digit_err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .carry_in_i  (carry_in_i),
`ifdef BCD_SUB_EN
        .sub_i       (sub_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .carry_out_o (carry_out_o),
        .digit_err_o (digit_err_o)
    );

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic all_valid(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] s, output logic co,
                                  output logic err);
        int r;
        err = !(all_valid(a) && all_valid(b));
        if (!err) begin
            if (!sub) begin
                r  = bcd_to_int(a) + bcd_to_int(b) + int'(cin);
                co = (r >= MODV);
                s  = int_to_bcd(r % MODV);
            end else begin
                r  = bcd_to_int(a) - bcd_to_int(b) - int'(cin);
                co = (r < 0);
                s  = int_to_bcd(r < 0 ? r + MODV : r);
            end
        end else begin
            int c = sub ? int'(!cin) : int'(cin);
            s = '0;
            for (int i = 0; i < DIGITS; i++) begin
                int ad = int'(a[4*i +: 4]);
                int bd = sub ? ((9 - int'(b[4*i +: 4])) & 15) : int'(b[4*i +: 4]);
                int t  = ad + bd + c;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) & 15);
                    c = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    c = 0;
                end
            end
            co = sub ? (c == 0) : (c == 1);
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd(input logic allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            if (allow_bad && $urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
            else r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Presents one operation and waits (bounded) for out_valid; leaves the result
    // in DONE. lat = clocks from accept edge to out_valid, -1 on timeout.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            output logic rdy_seen, output int lat);
        in_valid_i = 1'b1;
        a_i        = a;
        b_i        = b;
        carry_in_i = cin;
        sub_i      = sub;
        #1;
        rdy_seen = in_ready_o;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        if (!out_valid_o) lat = -1;
    endtask

    task automatic pop_result();
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic cin,
                                input logic sub);
        logic [W-1:0] es;
        logic eco, eerr, rdy;
        int lat;
        model(a, b, cin, sub, es, eco, eerr);
        drive_op(a, b, cin, sub, rdy, lat);
        tests_run++;
        if (rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s in_ready: got %0b want 1", name, rdy);
        end
        tests_run++;
        if (lat !== DIGITS) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, DIGITS);
        end
        tests_run++;
        if (sum_o !== es || carry_out_o !== eco || digit_err_o !== eerr) begin
            tests_failed++;
            $display("FAIL %s a=%h b=%h cin=%0b sub=%0b: got sum=%h co=%0b err=%0b want sum=%h co=%0b err=%0b",
                     name, a, b, cin, sub, sum_o, carry_out_o, digit_err_o, es, eco, eerr);
        end
        pop_result();
        tests_run++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s release: got out_valid=%0b in_ready=%0b want 0/1",
                     name, out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || sum_o !== '0 ||
            carry_out_o !== 1'b0 || digit_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%0b ov=%0b sum=%h co=%0b err=%0b want 0/0/0000/0/0",
                     in_ready_o, out_valid_o, sum_o, carry_out_o, digit_err_o);
        end
        reset_i = 1'b0;
        #1;
        tests_run++;
        if (in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release in_ready: got %0b want 1", in_ready_o);
        end
    endtask

    task automatic test_vectors();
        check_result("vec_1234_8766", 16'h1234, 16'h8766, 1'b0, 1'b0);
        check_result("vec_9999_cin",  16'h9999, 16'h0000, 1'b1, 1'b0);
        check_result("vec_bad_digit", 16'h00A0, 16'h0000, 1'b0, 1'b0);
        check_result("vec_zero",      16'h0000, 16'h0000, 1'b0, 1'b0);
        check_result("vec_max",       16'h9999, 16'h9999, 1'b1, 1'b0);
        check_result("vec_all_bad",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            check_result("random_add", rand_bcd(n >= 30), rand_bcd(n >= 30),
                         1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_hold();
        logic rdy;
        int lat;
        logic [W-1:0] es;
        logic eco, eerr;
        model(16'h0456, 16'h0789, 1'b0, 1'b0, es, eco, eerr);
        drive_op(16'h0456, 16'h0789, 1'b0, 1'b0, rdy, lat);
        tests_run++;
        if (lat !== DIGITS) begin
            tests_failed++;
            $display("FAIL hold latency: got %0d want %0d", lat, DIGITS);
        end
        in_valid_i = 1'b1;
        a_i        = 16'h1111;
        b_i        = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            tests_run++;
            if (out_valid_o !== 1'b1 || sum_o !== es || carry_out_o !== eco || in_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold cycle %0d: got ov=%0b sum=%h co=%0b rdy=%0b want 1/%h/%0b/0",
                         i, out_valid_o, sum_o, carry_out_o, in_ready_o, es, eco);
            end
        end
        in_valid_i = 1'b0;
        pop_result();
        // out_ready in IDLE must not disturb anything; last result stays visible.
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        tests_run++;
        if (out_valid_o !== 1'b0 || sum_o !== es || carry_out_o !== eco || in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_keep: got ov=%0b sum=%h co=%0b rdy=%0b want 0/%h/%0b/1",
                     out_valid_o, sum_o, carry_out_o, in_ready_o, es, eco);
        end
    endtask

    task automatic test_reset_abort();
        in_valid_i = 1'b1;
        a_i        = 16'h5555;
        b_i        = 16'h4444;
        carry_in_i = 1'b1;
        sub_i      = 1'b0;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || sum_o !== '0 || in_ready_o !== 1'b0 || carry_out_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: got ov=%0b sum=%h rdy=%0b co=%0b want 0/0000/0/0",
                     out_valid_o, sum_o, in_ready_o, carry_out_o);
        end
        reset_i = 1'b0;
        repeat (DIGITS + 2) @(posedge clk_i);
        #1;
        tests_run++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_output: got rdy=%0b ov=%0b want 1/0", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            check_result("back_to_back", rand_bcd(1'b0), rand_bcd(1'b0),
                         1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

`ifdef BCD_SUB_EN
    task automatic test_sub();
        check_result("sub_0100_0001", 16'h0100, 16'h0001, 1'b0, 1'b1);
        check_result("sub_0001_0002", 16'h0001, 16'h0002, 1'b0, 1'b1);
        for (int n = 0; n < 20; n++) begin
            check_result("random_sub", rand_bcd(n >= 16), rand_bcd(n >= 16),
                         1'($urandom_range(0, 1)), 1'b1);
        end
    endtask
`endif

    initial begin
        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        carry_in_i  = 1'b0;
        sub_i       = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        test_reset();
        test_vectors();
        test_random();
        test_hold();
        test_reset_abort();
        test_back_to_back();
`ifdef BCD_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
